// File: rtl/frequency_timer.sv
// frequency_timer
//
// Programmable period divider for the audio channels. Produces a one-cycle
// tick on timer_clock once every P system clocks, where P is the effective
// period (a programmed value of 0 selects the longest interval, 8192).
// The tick is used directly as a clock by channel step logic, so it is
// driven straight from a flop and never decoded from the counter.
//
// Ports:
//   system_clock  in   1   sole clock, all state changes on its rising edge
//   reset         in   1   asynchronous, active-high reset
//   period        in  13   tick interval in system clocks (0 means 8192)
//   timer_clock   out  1   registered tick, high one cycle per interval

module frequency_timer (
  input  logic        system_clock,
  input  logic        reset,
  input  logic [12:0] period,
  output logic        timer_clock
);

  // 14 bits so the 8192-cycle interval selected by period 0 fits
  logic [13:0] r_count;
  logic [13:0] w_effPeriod;

  // Expand the programmed period into the actual reload value
  assign w_effPeriod = (period == 13'd0) ? 14'd8192 : {1'b0, period};

  // Down-counter with tick generation. A count of 0 only exists right after
  // reset and means "not yet loaded": it loads without ticking. Reaching 1
  // reloads and ticks on the same edge, so no cycles are lost between
  // intervals. The period is only sampled on these load/reload edges, which
  // keeps a mid-count change from disturbing the interval in progress.
  always_ff @(posedge system_clock or posedge reset) begin
    if (reset) begin
      r_count     <= 14'd0;
      timer_clock <= 1'b0;
    end else if (r_count == 14'd1) begin
      r_count     <= w_effPeriod;
      timer_clock <= 1'b1;
    end else if (r_count == 14'd0) begin
      r_count     <= w_effPeriod;
      timer_clock <= 1'b0;
    end else begin
      r_count     <= r_count - 14'd1;
      timer_clock <= 1'b0;
    end
  end

endmodule

// File: tb/tb_frequency_timer.sv
// tb_frequency_timer
//
// Self-checking bench for frequency_timer. A reference model works in terms
// of edge indices: after E0 it schedules the next tick at "load edge + P",
// and every tick edge schedules the following one P edges later using the
// period present at that edge. Every edge is compared against the model,
// plus explicit spacing/latency checks for the directed scenarios.

module tb_frequency_timer;

  logic        system_clock;
  logic        reset;
  logic [12:0] period;
  logic        timer_clock;

  int checkCount;
  int errorCount;

  // Reference model state
  bit     loaded;
  longint edgeN;
  longint nextTick;
  bit     prevOut;
  longint lastRise;
  longint riseGap;
  longint riseEdge;
  bit     newRise;
  int     highCount;

  frequency_timer dut (
    .system_clock (system_clock),
    .reset        (reset),
    .period       (period),
    .timer_clock  (timer_clock)
  );

  // Free-running system clock, rising edges at 5, 15, 25, ...
  initial begin
    system_clock = 1'b0;
    forever #5 system_clock = ~system_clock;
  end

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input longint actual, input longint expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  function automatic longint effP(input logic [12:0] p);
    return (p == 13'd0) ? 8192 : longint'(p);
  endfunction

  // Drive a new period value between edges
  task automatic applyStimulus(input logic [12:0] newPeriod);
    period = newPeriod;
  endtask

  task automatic resetModel();
    loaded   = 1'b0;
    edgeN    = 0;
    prevOut  = 1'b0;
    lastRise = -1;
    riseGap  = -1;
    riseEdge = -1;
    newRise  = 1'b0;
  endtask

  // Advance one edge, update the model, compare DUT output 1 unit later
  task automatic stepEdge(input string tag);
    logic [12:0] sampled;
    bit expTick;
    @(posedge system_clock);
    sampled = period;
    #1;
    if (!loaded) begin
      loaded   = 1'b1;
      nextTick = edgeN + effP(sampled);
      expTick  = 1'b0;
    end else if (edgeN == nextTick) begin
      expTick  = 1'b1;
      nextTick = edgeN + effP(sampled);
    end else begin
      expTick = 1'b0;
    end
    checkOutput(tag, longint'(timer_clock), longint'(expTick));
    newRise = timer_clock && !prevOut;
    if (newRise) begin
      riseGap  = (lastRise >= 0) ? (edgeN - lastRise) : -1;
      riseEdge = edgeN;
      lastRise = edgeN;
    end
    if (timer_clock) highCount++;
    prevOut = timer_clock;
    edgeN++;
  endtask

  // Step until the DUT produces a rising tick, bounded by a cycle budget
  task automatic waitRise(input int budget, input string tag);
    int n;
    n = 0;
    newRise = 1'b0;
    while (!newRise && n < budget) begin
      stepEdge(tag);
      n++;
    end
    if (!newRise) checkOutput({tag, "_timeout"}, 0, 1);
  endtask

  // Asynchronous reset between edges; output must drop without a clock edge
  task automatic doReset(input string tag);
    #2;
    reset = 1'b1;
    #1;
    checkOutput(tag, longint'(timer_clock), 0);
    @(negedge system_clock);
    reset = 1'b0;
    resetModel();
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    highCount  = 0;
    resetModel();

    // Power-on reset, period 4
    reset = 1'b1;
    applyStimulus(13'd4);
    #1;
    checkOutput("resetValue", longint'(timer_clock), 0);
    #1;
    reset = 1'b0;

    // Period 4: 80 ticks over the 320 clocks following E0, first at E4
    stepEdge("p4_E0");
    highCount = 0;
    for (int i = 0; i < 320; i++) stepEdge("p4_run");
    checkOutput("p4_tickCount", highCount, 80);

    doReset("p4_reset");
    waitRise(10, "p4_first");
    checkOutput("p4_firstEdge", riseEdge, 4);

    // Period 10: constant spacing between rising edges
    doReset("p10_reset");
    applyStimulus(13'd10);
    waitRise(15, "p10_first");
    checkOutput("p10_firstEdge", riseEdge, 10);
    for (int k = 0; k < 5; k++) begin
      waitRise(15, "p10_run");
      checkOutput("p10_gap", riseGap, 10);
    end

    // Mid-count change 8 -> 3, three cycles after a tick
    doReset("mid_reset");
    applyStimulus(13'd8);
    waitRise(12, "mid_first");
    for (int i = 0; i < 3; i++) stepEdge("mid_wait");
    applyStimulus(13'd3);
    waitRise(12, "mid_cur");
    checkOutput("mid_curGap", riseGap, 8);
    waitRise(12, "mid_next");
    checkOutput("mid_newGap1", riseGap, 3);
    waitRise(12, "mid_next");
    checkOutput("mid_newGap2", riseGap, 3);

    // Reset while the tick is high, then first tick measured from new E0
    doReset("rst_pre");
    applyStimulus(13'd4);
    waitRise(10, "rst_wait");
    checkOutput("rst_highBefore", longint'(timer_clock), 1);
    doReset("rst_midHigh");
    waitRise(10, "rst_after");
    checkOutput("rst_firstEdge", riseEdge, 4);

    // Period 0 means 8192
    doReset("p0_reset");
    applyStimulus(13'd0);
    waitRise(8300, "p0_first");
    checkOutput("p0_firstEdge", riseEdge, 8192);
    waitRise(8300, "p0_second");
    checkOutput("p0_secondEdge", riseEdge, 16384);

    // Period 1: low through E0, then continuously high
    doReset("p1_reset");
    applyStimulus(13'd1);
    stepEdge("p1_E0");
    highCount = 0;
    for (int i = 0; i < 20; i++) stepEdge("p1_run");
    checkOutput("p1_highCount", highCount, 20);
    checkOutput("p1_riseEdge", riseEdge, 1);

    // Random periods, mid-count changes and resets against the model
    doReset("rnd_reset");
    applyStimulus(13'($urandom_range(2, 40)));
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        doReset("rnd_asyncReset");
      end else if (r < 12) begin
        applyStimulus(13'($urandom_range(2, 40)));
      end
      stepEdge("rnd_tick");
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
